// File: rtl/seg_scan_mux.sv
// Eight-digit multiplexed 7-segment scanner: two 4-digit BCD groups, per-frame
// snapshot, leading-zero blanking and an all-off gap at the start of each slot.
module seg_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dv10,
    input  logic [3:0] dv11,
    input  logic [3:0] dv12,
    input  logic [3:0] dv13,
    input  logic [3:0] dv20,
    input  logic [3:0] dv21,
    input  logic [3:0] dv22,
    input  logic [3:0] dv23,
    input  logic       lz_blank,
    input  logic [7:0] dp_mask,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int             PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  TC_VAL   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  BLANK_VAL = PW'(BLANK_CYC);

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_idx;
    logic [3:0]    r_snap [8];
    logic          r_snap_lz;
    logic          w_tc;
    logic [3:0]    w_digit;
    logic [3:0]    w_d1;
    logic [3:0]    w_d2;
    logic [3:0]    w_d3;
    logic          w_z1;
    logic          w_z2;
    logic          w_z3;
    logic          w_blank_slot;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_tc = (r_pcnt == TC_VAL);

    // Slot digit select and leading-zero chain within the active group.
    always_comb begin
        w_digit      = r_snap[r_idx];
        w_d1         = r_snap[{r_idx[2], 2'd1}];
        w_d2         = r_snap[{r_idx[2], 2'd2}];
        w_d3         = r_snap[{r_idx[2], 2'd3}];
        w_z3         = r_snap_lz && (w_d3 == 4'd0);
        w_z2         = w_z3 && (w_d2 == 4'd0);
        w_z1         = w_z2 && (w_d1 == 4'd0);
        case (r_idx[1:0])
            2'd3:    w_blank_slot = w_z3;
            2'd2:    w_blank_slot = w_z2;
            2'd1:    w_blank_slot = w_z1;
            default: w_blank_slot = 1'b0;
        endcase
    end

    // Prescaler, slot index and frame-start snapshot capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt    <= '0;
            r_idx     <= 3'd0;
            r_snap_lz <= 1'b0;
            frame     <= 1'b0;
            for (int i = 0; i < 8; i++) r_snap[i] <= 4'd0;
        end else begin
            r_pcnt <= w_tc ? '0 : r_pcnt + 1'b1;
            r_idx  <= w_tc ? r_idx + 3'd1 : r_idx;
            frame  <= w_tc && (r_idx == 3'd7);
            if (w_tc && (r_idx == 3'd7)) begin
                r_snap[0] <= dv10;
                r_snap[1] <= dv11;
                r_snap[2] <= dv12;
                r_snap[3] <= dv13;
                r_snap[4] <= dv20;
                r_snap[5] <= dv21;
                r_snap[6] <= dv22;
                r_snap[7] <= dv23;
                r_snap_lz <= lz_blank;
            end else begin
                r_snap_lz <= r_snap_lz;
            end
        end
    end

    // Registered display drive; the gap at slot start keeps all anodes off.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (r_pcnt < BLANK_VAL) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (w_blank_slot) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= ~dp_mask[r_idx];
        end else begin
            an  <= ~(8'h01 << r_idx);
            seg <= bcd_to_seg(w_digit);
            dp  <= ~dp_mask[r_idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with REFRESH_DIV = 4 and BLANK_CYC = 1.
module tb_seg_scan_mux;

    localparam int RD = 4;
    localparam int BC = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dv10, dv11, dv12, dv13, dv20, dv21, dv22, dv23;
    logic       lz_blank;
    logic [7:0] dp_mask;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t       sb_q [$];
    int         errors = 0;
    int         checks = 0;
    int         frames_seen = 0;
    int         m_pcnt;
    int         m_idx;
    logic [3:0] m_snap [8];
    logic       m_lz;
    logic [6:0] seg_tab [16];

    always #5 clk = ~clk;

    seg_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst),
        .dv10(dv10), .dv11(dv11), .dv12(dv12), .dv13(dv13),
        .dv20(dv20), .dv21(dv21), .dv22(dv22), .dv23(dv23),
        .lz_blank(lz_blank), .dp_mask(dp_mask),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    function automatic logic [3:0] din(input int i);
        case (i)
            0:       return dv10;
            1:       return dv11;
            2:       return dv12;
            3:       return dv13;
            4:       return dv20;
            5:       return dv21;
            6:       return dv22;
            default: return dv23;
        endcase
    endfunction

    // Expected outputs after the next edge, from model state before it.
    function automatic exp_t model_out();
        exp_t e;
        int   base;
        int   pos;
        logic blk;
        if (rst) begin
            e = {8'hFF, 7'h7F, 1'b1, 1'b0};
        end else begin
            e.frame = (m_pcnt == RD - 1) && (m_idx == 7);
            if (m_pcnt < BC) begin
                e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
                base = (m_idx / 4) * 4;
                pos  = m_idx % 4;
                blk  = m_lz && (pos != 0);
                for (int k = pos; k < 4; k++) if (m_snap[base + k] != 4'd0) blk = 1'b0;
                e.dp = ~dp_mask[m_idx];
                if (blk) begin
                    e.an = 8'hFF; e.seg = 7'h7F;
                end else begin
                    e.an  = ~(8'h01 << m_idx);
                    e.seg = seg_tab[m_snap[m_idx]];
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        exp_t       e;
        int         n_pcnt, n_idx;
        logic [3:0] n_snap [8];
        logic       n_lz;
        sb_q.push_back(model_out());
        n_lz = m_lz;
        for (int i = 0; i < 8; i++) n_snap[i] = m_snap[i];
        if (rst) begin
            n_pcnt = 0; n_idx = 0; n_lz = 1'b0;
            for (int i = 0; i < 8; i++) n_snap[i] = 4'd0;
        end else begin
            n_pcnt = (m_pcnt + 1) % RD;
            n_idx  = (m_pcnt == RD - 1) ? (m_idx + 1) % 8 : m_idx;
            if ((m_pcnt == RD - 1) && (m_idx == 7)) begin
                for (int i = 0; i < 8; i++) n_snap[i] = din(i);
                n_lz = lz_blank;
            end
        end
        @(posedge clk);
        m_pcnt = n_pcnt; m_idx = n_idx; m_lz = n_lz;
        for (int i = 0; i < 8; i++) m_snap[i] = n_snap[i];
        #1;
        e = sb_q.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("frame", 32'(frame), 32'(e.frame));
        chk("one_hot_an", 32'($countones(~an) <= 1), 32'd1);
        if (frame === 1'b1) frames_seen++;
    endtask

    task automatic run_to_idx(input int target);
        int n;
        n = 0;
        while ((m_idx != target || m_pcnt != 0) && n < 100) begin
            step();
            n++;
        end
        chk("run_to_idx_bound", 32'(n < 100), 32'd1);
    endtask

    initial begin
        int f0;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        m_pcnt = 0; m_idx = 0; m_lz = 1'b0;
        for (int i = 0; i < 8; i++) m_snap[i] = 4'd0;
        rst = 1'b1; lz_blank = 1'b0; dp_mask = 8'h00;
        {dv13, dv12, dv11, dv10} = {4'd4, 4'd3, 4'd2, 4'd1};
        {dv23, dv22, dv21, dv20} = {4'd8, 4'd7, 4'd6, 4'd5};
        repeat (2) step();
        rst = 1'b0;

        // First frame shows zeros; each 32-cycle window holds one frame pulse.
        step();
        step();
        chk("post_reset_slot0_an", 32'(an), 32'hFE);
        chk("post_reset_slot0_seg", 32'(seg), 32'h40);
        f0 = frames_seen;
        repeat (30) step();
        chk("frame_count_w1", 32'(frames_seen - f0), 32'd1);
        f0 = frames_seen;
        repeat (32) step();
        chk("frame_count_w2", 32'(frames_seen - f0), 32'd1);

        // Leading-zero blanking, including dp on a blanked slot.
        {dv13, dv12, dv11, dv10} = {4'd0, 4'd0, 4'd0, 4'd7};
        lz_blank = 1'b1; dp_mask = 8'h04;
        repeat (64) step();
        {dv13, dv12, dv11, dv10} = {4'd0, 4'd0, 4'd0, 4'd0};
        {dv23, dv22, dv21, dv20} = {4'd0, 4'd3, 4'd0, 4'd9};
        repeat (64) step();

        // Mid-frame change of value 2 must wait for the next snapshot.
        lz_blank = 1'b0; dp_mask = 8'h00;
        {dv23, dv22, dv21, dv20} = {4'd1, 4'd1, 4'd1, 4'd1};
        repeat (64) step();
        run_to_idx(5);
        {dv23, dv22, dv21, dv20} = {4'd2, 4'd2, 4'd2, 4'd2};
        run_to_idx(7);
        step();
        step();
        chk("stale_slot7_seg", 32'(seg), 32'h79);
        repeat (40) step();

        // Dash code and live decimal-point mask.
        dv13 = 4'hC; dp_mask = 8'h10;
        repeat (64) step();

        // Reset in the middle of slot 6.
        run_to_idx(6);
        step();
        rst = 1'b1;
        step();
        chk("mid_reset_an", 32'(an), 32'hFF);
        rst = 1'b0;
        repeat (40) step();

        // Mixed patterns.
        for (int r = 0; r < 8; r++) begin
            {dv13, dv12, dv11, dv10} = 16'($urandom_range(0, 65535));
            {dv23, dv22, dv21, dv20} = 16'($urandom_range(0, 65535));
            lz_blank = 1'($urandom_range(0, 1));
            dp_mask  = 8'($urandom_range(0, 255));
            repeat (24) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 1000: leading cycles of each slot with all anodes off (anti-ghosting); must be less than REFRESH_DIV.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 dv10..dv13  in  4 each  BCD digits of value 1, units..thousands, from the binary-to-BCD stage.
REQ-006 dv20..dv23  in  4 each  BCD digits of value 2, units..thousands.
REQ-007 lz_blank  in  1  1 = blank leading zeros independently within each 4-digit group.
REQ-008 dp_mask  in  8  1 = light the decimal point in slot i.
REQ-009 an  out  8  active-low anode enables; an[i] drives slot i.
REQ-010 seg  out  7  active-low cathodes, seg[6:0] = {g,f,e,d,c,b,a}.
REQ-011 dp  out  1  active-low decimal point.
REQ-012 frame  out  1  one-cycle pulse when a new digit snapshot is captured.

Function
REQ-013 Prescaler pcnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; terminal count (tc) is pcnt = REFRESH_DIV-1.
REQ-014 Slot index idx (3 bits) SHALL increment by 1 on tc and wrap 7 -> 0.
REQ-015 Slot mapping: idx 0..3 -> dv10..dv13; idx 4..7 -> dv20..dv23.
REQ-016 All 32 digit bits and lz_blank SHALL be captured into snapshot registers on the cycle where tc and idx = 7 (frame start); frame SHALL pulse on that same cycle.
REQ-017 The display SHALL use only snapshot values, so input changes mid-frame never mix values from two conversions.
REQ-018 Decode: 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000.
REQ-019 Codes 10..15 SHALL decode to a dash (1111111 with g low = 0111111).
REQ-020 Leading-zero rule (when snapshot lz_blank = 1), per group:
  - thousands digit blank if it is 0;
  - hundreds digit blank if it is 0 and thousands is blank;
  - tens digit blank if it is 0 and hundreds is blank;
  - units digit is never blanked.
REQ-021 A blanked slot SHALL drive an = 8'hFF and seg = 7'h7F for the whole slot; its dp follows dp_mask.
REQ-022 When pcnt < BLANK_CYC: an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-023 Otherwise: exactly one an bit (an[idx]) low; seg is the decode of the slot digit; dp = ~dp_mask[idx].
REQ-024 dp_mask SHALL be sampled live (not snapshotted).
REQ-025 an, seg and dp SHALL be registered, lagging pcnt/idx by exactly one clock.
REQ-026 At no time SHALL more than one an bit be low.

Reset
REQ-027 While rst = 1 at a clock edge, all of the following SHALL hold on the next cycle:
  - pcnt = 0, idx = 0, snapshot digits = 0, snapshot lz_blank = 0;
  - an = 8'hFF, seg = 7'h7F, dp = 1, frame = 0.
REQ-028 Reset asserted mid-slot or mid-frame SHALL abort the scan immediately.
REQ-029 After rst deasserts, scanning SHALL restart from slot 0 with zero snapshots (shows 0000 0000) until the first frame pulse.

Verification (REFRESH_DIV = 4, BLANK_CYC = 1)
REQ-030 Reset, then 32 cycles with digits 1,2,3,4 / 5,6,7,8 -> an walks FE, FD, ... 7F, one slot per 4 cycles; each slot shows an = FF for its first cycle; frame pulses once every 32 cycles.
REQ-031 Value 1 = 0,0,0,7 (units = 7), lz_blank = 1 -> slots 1..3 stay dark and slot 0 shows 1111000; with value 1 = 0,0,0,0, slot 0 shows 1000000.
REQ-032 Change dv2x from 1111 to 2222 at mid-frame (idx = 5) -> slots 6 and 7 still show 1 and the new 2s appear only after the next frame pulse.
REQ-033 dv13 = 4'hC -> slot 3 shows 0111111; dp_mask = 8'h10 -> dp = 0 only during the non-blank cycles of slot 4.
REQ-034 Assert rst for 1 cycle while idx = 6 -> next cycle an = FF, idx = 0, and snapshots are cleared.
REQ-035 Every cycle of all runs -> popcount(~an) <= 1.
